// File: rtl/fifo_bh_pkg.sv
// Shared helpers for the bh FIFO family: count-width sizing and a parameter legality check.
package fifo_bh_pkg;

  function automatic int cnt_width(input int depth_lg2);
    return depth_lg2 + 1;
  endfunction

  function automatic bit params_legal(input int data_width,
                                      input int depth_lg2,
                                      input int depth,
                                      input int min_space,
                                      input int ae_level);
    bit ok;
    ok = 1'b1;
    if (data_width < 1) ok = 1'b0;
    if (depth_lg2 < 1 || depth_lg2 > 30) ok = 1'b0;
    else if (depth != (1 << depth_lg2)) ok = 1'b0;
    if (min_space < 1 || min_space > depth) ok = 1'b0;
    if (ae_level < 0 || ae_level > depth - 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fifo_bh_sdp_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port, no array reset.
module fifo_bh_sdp_ram #(
  parameter int DATA_WIDTH = 66,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_bh_sync_fwft_param.sv
// Single-clock first-word-fall-through FIFO with count, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
module fifo_bh_sync_fwft_param
  import fifo_bh_pkg::*;
#(
  parameter int DATA_WIDTH         = 66,
  parameter int DEPTH_LG2          = 2,
  parameter int DEPTH              = 2 ** DEPTH_LG2,
  parameter int MIN_SPACE          = 2,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [DEPTH_LG2:0]    count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int CNT_W = cnt_width(DEPTH_LG2);
  localparam int PTR_W = DEPTH_LG2;

  if (!params_legal(DATA_WIDTH, DEPTH_LG2, DEPTH, MIN_SPACE, ALMOST_EMPTY_LEVEL)) begin : g_param_check
    $error("fifo_bh_sync_fwft_param: illegal parameter combination");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  // All status flags decode from the count register only, so no input reaches an output.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign wr_acc = wren_i & ~full  & ~clr_i;
  assign rd_acc = rden_i & ~empty & ~clr_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wren_i && full)  overflow_d  = 1'b1;
      if (rden_i && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_bh_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PTR_W),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_o)
  );

  assign empty_o        = empty;
  assign valid_o        = ~empty;
  assign full_o         = full;
  assign almost_full_o  = (CNT_W'(DEPTH) - count_q) < CNT_W'(MIN_SPACE);
  assign almost_empty_o = (count_q <= CNT_W'(ALMOST_EMPTY_LEVEL));
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_bh_sync_fwft_param.sv
// Directed self-checking bench for fifo_bh_sync_fwft_param at DEPTH=4, MIN_SPACE=2, AE level 1.
module tb_fifo_bh_sync_fwft_param;

  localparam int DW = 66;

  logic          clk;
  logic          rst;
  logic          clr_i;
  logic          wren_i;
  logic [DW-1:0] wdata_i;
  logic          rden_i;
  logic [DW-1:0] rdata_o;
  logic          valid_o, empty_o, full_o, almost_full_o, almost_empty_o;
  logic [2:0]    count_o;
  logic          overflow_o, underflow_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fifo_bh_sync_fwft_param #(
    .DATA_WIDTH         (66),
    .DEPTH_LG2          (2),
    .DEPTH              (4),
    .MIN_SPACE          (2),
    .ALMOST_EMPTY_LEVEL (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (clr_i),
    .wren_i         (wren_i),
    .wdata_i        (wdata_i),
    .rden_i         (rden_i),
    .rdata_o        (rdata_o),
    .valid_o        (valid_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren_i = 1'b0;
    rden_i = 1'b0;
    clr_i  = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wren_i  = 1'b1;
    wdata_i = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [8:0] got;
    logic [8:0] exp;
    got = {count_o, empty_o, valid_o, full_o, almost_full_o, almost_empty_o, overflow_o, underflow_o};
    exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (got !== exp) $display("FAIL reset_state: got %b expected %b", got, exp);
    else pass_cnt++;
  endtask

  task automatic test_fill_thresholds();
    push(66'h1);
    total_cnt++;
    if (rdata_o !== 66'h1 || count_o !== 3'd1 || empty_o !== 1'b0 || almost_empty_o !== 1'b1)
      $display("FAIL first_write: rdata %h cnt %0d empty %b ae %b expected 1 1 0 1", rdata_o, count_o, empty_o, almost_empty_o);
    else pass_cnt++;
    push(66'h2);
    total_cnt++;
    if (almost_empty_o !== 1'b0 || almost_full_o !== 1'b0 || count_o !== 3'd2)
      $display("FAIL second_write: ae %b af %b cnt %0d expected 0 0 2", almost_empty_o, almost_full_o, count_o);
    else pass_cnt++;
    push(66'h3);
    total_cnt++;
    if (almost_full_o !== 1'b1 || full_o !== 1'b0 || count_o !== 3'd3 || rdata_o !== 66'h1)
      $display("FAIL third_write: af %b full %b cnt %0d rdata %h expected 1 0 3 1", almost_full_o, full_o, count_o, rdata_o);
    else pass_cnt++;
  endtask

  task automatic test_overflow_drain();
    logic [DW-1:0] exp_d;
    push(66'h4);
    total_cnt++;
    if (full_o !== 1'b1 || count_o !== 3'd4 || overflow_o !== 1'b0)
      $display("FAIL fill_full: full %b cnt %0d ovf %b expected 1 4 0", full_o, count_o, overflow_o);
    else pass_cnt++;
    push(66'h3FF);
    total_cnt++;
    if (full_o !== 1'b1 || count_o !== 3'd4 || overflow_o !== 1'b1 || rdata_o !== 66'h1)
      $display("FAIL overflow_write: full %b cnt %0d ovf %b rdata %h expected 1 4 1 1", full_o, count_o, overflow_o, rdata_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      exp_d = DW'(i + 1);
      total_cnt++;
      if (rdata_o !== exp_d || valid_o !== 1'b1)
        $display("FAIL drain_data[%0d]: rdata %h valid %b expected %h 1", i, rdata_o, valid_o, exp_d);
      else pass_cnt++;
      rden_i = 1'b1;
      tick();
      idle();
    end
    total_cnt++;
    if (empty_o !== 1'b1 || count_o !== 3'd0 || overflow_o !== 1'b1 || underflow_o !== 1'b0)
      $display("FAIL drain_empty: empty %b cnt %0d ovf %b unf %b expected 1 0 1 0", empty_o, count_o, overflow_o, underflow_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_head;
    push(66'd100);
    push(66'd101);
    exp_head = 66'd100;
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (rdata_o !== exp_head)
        $display("FAIL b2b_data[%0d]: rdata %0d expected %0d", i, rdata_o, exp_head);
      else pass_cnt++;
      wren_i  = 1'b1;
      rden_i  = 1'b1;
      wdata_i = DW'(102 + i);
      tick();
      idle();
      exp_head = exp_head + 66'd1;
      total_cnt++;
      if (count_o !== 3'd2)
        $display("FAIL b2b_count[%0d]: count %0d expected 2", i, count_o);
      else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (rdata_o !== DW'(120 + i))
        $display("FAIL b2b_tail[%0d]: rdata %0d expected %0d", i, rdata_o, 120 + i);
      else pass_cnt++;
      rden_i = 1'b1;
      tick();
      idle();
    end
    total_cnt++;
    if (empty_o !== 1'b1 || underflow_o !== 1'b0)
      $display("FAIL b2b_end: empty %b unf %b expected 1 0", empty_o, underflow_o);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    wren_i  = 1'b1;
    rden_i  = 1'b1;
    wdata_i = 66'hA;
    tick();
    idle();
    total_cnt++;
    if (underflow_o !== 1'b1 || count_o !== 3'd1 || rdata_o !== 66'hA || valid_o !== 1'b1)
      $display("FAIL underflow_both: unf %b cnt %0d rdata %h valid %b expected 1 1 a 1", underflow_o, count_o, rdata_o, valid_o);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    push(66'hB);
    push(66'hC);
    total_cnt++;
    if (count_o !== 3'd3 || overflow_o !== 1'b1 || underflow_o !== 1'b1)
      $display("FAIL clear_pre: cnt %0d ovf %b unf %b expected 3 1 1", count_o, overflow_o, underflow_o);
    else pass_cnt++;
    clr_i   = 1'b1;
    wren_i  = 1'b1;
    wdata_i = 66'h77;
    tick();
    idle();
    total_cnt++;
    if (count_o !== 3'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || underflow_o !== 1'b0 || almost_empty_o !== 1'b1)
      $display("FAIL clear_state: cnt %0d empty %b ovf %b unf %b ae %b expected 0 1 0 0 1", count_o, empty_o, overflow_o, underflow_o, almost_empty_o);
    else pass_cnt++;
    push(66'h88);
    total_cnt++;
    if (rdata_o !== 66'h88 || count_o !== 3'd1)
      $display("FAIL clear_dropped_write: rdata %h cnt %0d expected 88 1", rdata_o, count_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [8:0] got;
    logic [8:0] exp;
    push(66'h21);
    push(66'h22);
    total_cnt++;
    if (count_o !== 3'd3 || almost_full_o !== 1'b1)
      $display("FAIL areset_pre: cnt %0d af %b expected 3 1", count_o, almost_full_o);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    got = {count_o, empty_o, valid_o, full_o, almost_full_o, almost_empty_o, overflow_o, underflow_o};
    exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (got !== exp) $display("FAIL areset_midcycle: got %b expected %b", got, exp);
    else pass_cnt++;
    #1;
    rst = 1'b0;
    tick();
    push(66'h5);
    total_cnt++;
    if (rdata_o !== 66'h5 || count_o !== 3'd1 || valid_o !== 1'b1)
      $display("FAIL areset_after: rdata %h cnt %0d valid %b expected 5 1 1", rdata_o, count_o, valid_o);
    else pass_cnt++;
  endtask

  initial begin
    rst     = 1'b1;
    wdata_i = '0;
    idle();
    #3;
    test_reset();
    tick();
    #2;
    rst = 1'b0;
    tick();
    test_reset();
    test_fill_thresholds();
    test_overflow_drain();
    test_back_to_back();
    test_underflow();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
